// File: rtl/half_adder.sv
// ---------------------------------------------------------------------------
// half_adder
// Multi-lane 1-bit half adder (Q = A ^ B, Co = A & B per lane) with a
// saturating carry-event counter for debug/coverage.
//
// Parameters:
//   WIDTH      number of independent lanes (>= 1)
//   REGISTERED 1: Q/Co/out_valid registered, 1-cycle latency
//              0: Q/Co follow A/B combinationally, out_valid = in_valid
//   CNT_W      width of carry_cnt (>= 1)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input beat qualifier (no backpressure)
//   A, B       operands, one bit per lane
//   Q, Co      per-lane sum / carry
//   out_valid  Q/Co hold a valid result
//   cnt_clr    synchronous clear of carry_cnt (wins over increment)
//   carry_cnt  accepted beats with at least one lane carry, saturating
// ---------------------------------------------------------------------------
module half_adder #(
  parameter int unsigned WIDTH      = 1,
  parameter int unsigned REGISTERED = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Co,
  output logic             out_valid,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] carry_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] sum_c;
  logic [WIDTH-1:0] carry_c;
  logic             any_carry_c;
  logic [CNT_W-1:0] cnt_q;

  // Lane arithmetic; lanes never interact.
  assign sum_c       = A ^ B;
  assign carry_c     = A & B;
  assign any_carry_c = |carry_c;

  // Carry-event counter: always registered, saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (in_valid && any_carry_c && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign carry_cnt = cnt_q;

  generate
    if (REGISTERED != 0) begin : g_reg
      logic [WIDTH-1:0] q_r;
      logic [WIDTH-1:0] co_r;
      logic             vld_r;

      // Result register: loads on accepted beats, holds across bubbles.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q_r   <= '0;
          co_r  <= '0;
          vld_r <= 1'b0;
        end else begin
          vld_r <= in_valid;
          if (in_valid) begin
            q_r  <= sum_c;
            co_r <= carry_c;
          end
        end
      end

      assign Q         = q_r;
      assign Co        = co_r;
      assign out_valid = vld_r;
    end else begin : g_comb
      // Q/Co stay live even in reset; only the qualifier is forced low.
      assign Q         = sum_c;
      assign Co        = carry_c;
      assign out_valid = in_valid & rst_n;
    end
  endgenerate

endmodule

// File: tb/tb_half_adder.sv
module tb_half_adder;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         cnt_clr;

  logic [W-1:0] r_q, r_co, c_q, c_co, s_q, s_co;
  logic         r_vld, c_vld, s_vld;
  logic [15:0]  r_cnt, c_cnt;
  logic [1:0]   s_cnt;
  logic [0:0]   w1_q, w1_co, w1_cnt;
  logic         w1_vld;

  int total;
  int bad;

  half_adder #(.WIDTH(W), .REGISTERED(1), .CNT_W(16)) u_reg (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(A), .B(B),
    .Q(r_q), .Co(r_co), .out_valid(r_vld), .cnt_clr(cnt_clr), .carry_cnt(r_cnt));

  half_adder #(.WIDTH(W), .REGISTERED(1), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(A), .B(B),
    .Q(s_q), .Co(s_co), .out_valid(s_vld), .cnt_clr(cnt_clr), .carry_cnt(s_cnt));

  half_adder #(.WIDTH(W), .REGISTERED(0), .CNT_W(16)) u_comb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(A), .B(B),
    .Q(c_q), .Co(c_co), .out_valid(c_vld), .cnt_clr(cnt_clr), .carry_cnt(c_cnt));

  half_adder #(.WIDTH(1), .REGISTERED(1), .CNT_W(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(A[0]), .B(B[0]),
    .Q(w1_q), .Co(w1_co), .out_valid(w1_vld), .cnt_clr(cnt_clr), .carry_cnt(w1_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: each lane is a 1-bit binary addition; sum = LSB, carry = MSB.
  function automatic logic [2*W-1:0] lane_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] q, co;
    int s;
    for (int i = 0; i < W; i++) begin
      s     = int'(a[i]) + int'(b[i]);
      q[i]  = (s % 2) == 1;
      co[i] = (s / 2) == 1;
    end
    return {co, q};
  endfunction

  // Behavioural model of the registered instances.
  logic [W-1:0] m_q, m_co;
  logic         m_vld;
  int           m_cnt16, m_cnt2, m_cnt1;
  logic [2*W-1:0] m_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q = '0; m_co = '0; m_vld = 1'b0;
      m_cnt16 = 0; m_cnt2 = 0; m_cnt1 = 0;
    end else begin
      m_vld = in_valid;
      if (in_valid) begin
        m_res = lane_add(A, B);
        m_q   = m_res[W-1:0];
        m_co  = m_res[2*W-1:W];
      end
      if (cnt_clr) begin
        m_cnt16 = 0; m_cnt2 = 0; m_cnt1 = 0;
      end else if (in_valid) begin
        if ((A & B) != 0) begin
          m_cnt16 = (m_cnt16 < 65535) ? m_cnt16 + 1 : m_cnt16;
          m_cnt2  = (m_cnt2 < 3) ? m_cnt2 + 1 : m_cnt2;
        end
        if ((A[0] & B[0]) == 1'b1) m_cnt1 = 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [2*W-1:0] cres;
    cres = lane_add(A, B);
    chk("reg_q",    32'(r_q),    32'(m_q));
    chk("reg_co",   32'(r_co),   32'(m_co));
    chk("reg_vld",  32'(r_vld),  32'(m_vld));
    chk("reg_cnt",  32'(r_cnt),  32'(m_cnt16));
    chk("sat_cnt",  32'(s_cnt),  32'(m_cnt2));
    chk("w1_q",     32'(w1_q),   32'(m_q[0]));
    chk("w1_co",    32'(w1_co),  32'(m_co[0]));
    chk("w1_cnt",   32'(w1_cnt), 32'(m_cnt1));
    chk("comb_q",   32'(c_q),    32'(cres[W-1:0]));
    chk("comb_co",  32'(c_co),   32'(cres[2*W-1:W]));
    chk("comb_vld", 32'(c_vld),  32'(in_valid & rst_n));
    chk("comb_cnt", 32'(c_cnt),  32'(m_cnt16));
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] co;
  } vec_t;

  vec_t vecs[6];

  initial begin
    total = 0;
    bad   = 0;
    vecs[0] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
    vecs[1] = '{4'b0000, 4'b1111, 4'b1111, 4'b0000};
    vecs[2] = '{4'b1111, 4'b0000, 4'b1111, 4'b0000};
    vecs[3] = '{4'b1111, 4'b1111, 4'b0000, 4'b1111};
    vecs[4] = '{4'b1100, 4'b1010, 4'b0110, 4'b1000};
    vecs[5] = '{4'b0101, 4'b0011, 4'b0110, 4'b0001};

    rst_n = 1'b0; in_valid = 1'b1; A = 4'hF; B = 4'hF; cnt_clr = 1'b0;
    #3;
    // Reset state: registered outputs zero, comb out_valid forced low.
    chk("rst_q",    32'(r_q),   32'h0);
    chk("rst_co",   32'(r_co),  32'h0);
    chk("rst_vld",  32'(r_vld), 32'h0);
    chk("rst_cnt",  32'(r_cnt), 32'h0);
    chk("rst_cvld", 32'(c_vld), 32'h0);
    chk("rst_cco",  32'(c_co),  32'hF);
    repeat (2) @(negedge clk);
    in_valid = 1'b0; A = '0; B = '0;
    rst_n = 1'b1;
    cyc();

    // Truth table / multi-lane vectors, back to back.
    foreach (vecs[k]) begin
      in_valid = 1'b1; A = vecs[k].a; B = vecs[k].b;
      cyc();
      chk("tt_q",   32'(r_q),   32'(vecs[k].q));
      chk("tt_co",  32'(r_co),  32'(vecs[k].co));
      chk("tt_vld", 32'(r_vld), 32'h1);
      chk("tt_w1q", 32'(w1_q),  32'(vecs[k].q[0]));
      chk("tt_w1c", 32'(w1_co), 32'(vecs[k].co[0]));
      check_model();
    end

    // Bubble: result held, out_valid drops after one cycle.
    in_valid = 1'b1; A = 4'hF; B = 4'hF;
    cyc();
    chk("bub_vld0", 32'(r_vld), 32'h1);
    in_valid = 1'b0; A = 4'h3; B = 4'h0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("bub_vld", 32'(r_vld), 32'h0);
      chk("bub_q",   32'(r_q),   32'h0);
      chk("bub_co",  32'(r_co),  32'hF);
    end

    // Multi-lane with counter from zero.
    cnt_clr = 1'b1;
    cyc();
    cnt_clr = 1'b0;
    chk("ml_cnt0", 32'(r_cnt), 32'h0);
    in_valid = 1'b1; A = 4'b1100; B = 4'b1010;
    cyc();
    chk("ml_q",    32'(r_q),   32'b0110);
    chk("ml_co",   32'(r_co),  32'b1000);
    chk("ml_cnt1", 32'(r_cnt), 32'h1);

    // Saturation of the 2-bit counter; clear beats a simultaneous carry.
    in_valid = 1'b0; cnt_clr = 1'b1;
    cyc();
    chk("sat_cnt0", 32'(s_cnt), 32'h0);
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1; A = 4'h1; B = 4'h1; cnt_clr = (i == 5);
      cyc();
      chk("sat_step", 32'(s_cnt), (i == 5) ? 32'h0 : ((i >= 3) ? 32'h3 : 32'(i)));
    end
    cnt_clr = 1'b0;
    cyc();
    chk("sat_after", 32'(s_cnt), 32'h1);

    // Asynchronous reset mid-stream, between edges.
    in_valid = 1'b1; A = 4'hF; B = 4'hF;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_q",    32'(r_q),   32'h0);
    chk("ar_co",   32'(r_co),  32'h0);
    chk("ar_vld",  32'(r_vld), 32'h0);
    chk("ar_cnt",  32'(r_cnt), 32'h0);
    chk("ar_scnt", 32'(s_cnt), 32'h0);
    chk("ar_cvld", 32'(c_vld), 32'h0);
    @(posedge clk);
    #1;
    chk("ar_hold_vld", 32'(r_vld), 32'h0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b1; A = 4'h1; B = 4'h0;
    cyc();
    chk("ar_post_q",   32'(r_q),   32'h1);
    chk("ar_post_co",  32'(r_co),  32'h0);
    chk("ar_post_vld", 32'(r_vld), 32'h1);

    // Combinational mode responds with no clock edge.
    in_valid = 1'b1; A = 4'h0; B = 4'hF;
    #1;
    chk("cm_q0",  32'(c_q),  32'hF);
    chk("cm_co0", 32'(c_co), 32'h0);
    A = 4'hF;
    #1;
    chk("cm_q1",  32'(c_q),   32'h0);
    chk("cm_co1", 32'(c_co),  32'hF);
    chk("cm_vld1", 32'(c_vld), 32'h1);
    in_valid = 1'b0;
    #1;
    chk("cm_vld0", 32'(c_vld), 32'h0);
    chk("cm_qinv", 32'(c_q),   32'h0);
    @(negedge clk);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      A        = W'($urandom);
      B        = W'($urandom);
      cnt_clr  = ($urandom_range(0, 31) == 0);
      cyc();
      check_model();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
